// File: rtl/vme_reg_master.sv
// Single-outstanding bus initiator for a VMEAddr/VMERdMem/VMEWrMem register bank.
// Commands in on a valid/ready port; read data or a timeout error back on a valid/ready port.
module vme_reg_master #(
    parameter int ADDR_HI = 2,
    parameter int ADDR_LO = 2,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       Clk,
    input  logic                       Rst,
    // Both ports: a transfer happens on a rising edge where valid and ready are both high;
    // once valid is raised its payload is held unchanged until that edge.
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [ADDR_HI-ADDR_LO:0]   cmd_addr,
    input  logic [DATA_W-1:0]          cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic [1:0]                 dbg_state,
    output logic [ADDR_HI:ADDR_LO]     VMEAddr,
    output logic [DATA_W-1:0]          VMEWrData,
    output logic                       VMERdMem,
    output logic                       VMEWrMem,
    input  logic [DATA_W-1:0]          VMERdData,
    input  logic                       VMERdDone,
    input  logic                       VMEWrDone
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic                   wr_q, wr_d;
    logic [ADDR_HI:ADDR_LO] addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   rd_strb_q, rd_strb_d;
    logic                   wr_strb_q, wr_strb_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   valid_q, valid_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done;

    // Only the Done matching the latched direction counts.
    assign done = wr_q ? VMEWrDone : VMERdDone;

    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_strb_d = 1'b0;
        wr_strb_d = 1'b0;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    wr_d      = cmd_write;
                    addr_d    = cmd_addr;
                    if (cmd_write) begin
                        wdata_d = cmd_wdata;
                    end
                    rd_strb_d = ~cmd_write;
                    wr_strb_d = cmd_write;
                    state_d   = ST_STROBE;
                end
            end
            ST_STROBE: begin
                cnt_d   = 16'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    rdata_d = wr_q ? '0 : VMERdData;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_RESP);
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_strb_q <= 1'b0;
            wr_strb_q <= 1'b0;
            cnt_q     <= 16'd0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_strb_q <= rd_strb_d;
            wr_strb_q <= wr_strb_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;
    assign VMEAddr   = addr_q;
    assign VMEWrData = wdata_q;
    assign VMERdMem  = rd_strb_q;
    assign VMEWrMem  = wr_strb_q;

endmodule
